// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-channel result FIFOs drained round-robin onto one register-file write port.
// Optional macro WB_ARB_PERF_EN adds 32-bit write and stall performance counters.
module wb_arbiter #(
    parameter int N_CH   = 2,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_in,
    input  logic [N_CH-1:0]          ch_valid,
    output logic [N_CH-1:0]          ch_ready,
    input  logic [N_CH*ADDR_W-1:0]   ch_rd_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_rd_data,
    input  logic [N_CH-1:0]          ch_exc,
    output logic                     rd_wena_WB,
    output logic [ADDR_W-1:0]        rd_addr_WB,
    output logic [DATA_W-1:0]        rd_data_WB,
    output logic [N_CH-1:0]          grant_WB,
    output logic                     exc_WB,
    output logic                     busy
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]              perf_wb_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int SEL_W = $clog2(N_CH);

    logic [PTR_W-1:0]  r_wrPtr    [N_CH];
    logic [PTR_W-1:0]  r_rdPtr    [N_CH];
    logic [ADDR_W-1:0] r_fifoAddr [N_CH][DEPTH];
    logic [DATA_W-1:0] r_fifoData [N_CH][DEPTH];
    logic              r_fifoExc  [N_CH][DEPTH];
    logic [SEL_W-1:0]  r_lastGrant;

    logic [N_CH-1:0]   w_full;
    logic [N_CH-1:0]   w_empty;
    logic [N_CH-1:0]   w_push;
    logic [N_CH-1:0]   w_pop;
    logic              w_anyReq;
    logic [SEL_W-1:0]  w_sel;
    logic [SEL_W-1:0]  w_cand;
    logic [ADDR_W-1:0] w_headAddr;
    logic [DATA_W-1:0] w_headData;
    logic              w_headExc;

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_empty[i] = (r_wrPtr[i] == r_rdPtr[i]);
            w_full[i]  = (r_wrPtr[i][AW] != r_rdPtr[i][AW]) &&
                         (r_wrPtr[i][AW-1:0] == r_rdPtr[i][AW-1:0]);
        end
        ch_ready = ~w_full & {N_CH{~flush_in}};
        w_push   = ch_valid & ch_ready;
    end

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_sel    = r_lastGrant;
        w_cand   = '0;
        w_anyReq = 1'b0;
        for (int k = N_CH; k >= 1; k--) begin
            w_cand = SEL_W'((int'(r_lastGrant) + k) % N_CH);
            if (!w_empty[w_cand]) begin
                w_sel    = w_cand;
                w_anyReq = 1'b1;
            end
        end
        w_pop = '0;
        if (w_anyReq && !flush_in) begin
            w_pop[w_sel] = 1'b1;
        end
        w_headAddr = r_fifoAddr[w_sel][r_rdPtr[w_sel][AW-1:0]];
        w_headData = r_fifoData[w_sel][r_rdPtr[w_sel][AW-1:0]];
        w_headExc  = r_fifoExc[w_sel][r_rdPtr[w_sel][AW-1:0]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (w_push[i]) begin
                r_fifoAddr[i][r_wrPtr[i][AW-1:0]] <= ch_rd_addr[i*ADDR_W +: ADDR_W];
                r_fifoData[i][r_wrPtr[i][AW-1:0]] <= ch_rd_data[i*DATA_W +: DATA_W];
                r_fifoExc[i][r_wrPtr[i][AW-1:0]]  <= ch_exc[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_in) begin
            for (int i = 0; i < N_CH; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_push[i]) begin
                    r_wrPtr[i] <= r_wrPtr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rdPtr[i] <= r_rdPtr[i] + PTR_W'(1);
                end
            end
        end
    end

    // Address 0 is the hardwired zero register, so writes to it are dropped like exceptions.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_wena_WB  <= 1'b0;
            rd_addr_WB  <= '0;
            rd_data_WB  <= '0;
            grant_WB    <= '0;
            exc_WB      <= 1'b0;
            r_lastGrant <= SEL_W'(N_CH - 1);
        end else if (flush_in || !w_anyReq) begin
            rd_wena_WB <= 1'b0;
            grant_WB   <= '0;
            exc_WB     <= 1'b0;
        end else begin
            rd_wena_WB  <= !w_headExc && (w_headAddr != '0);
            rd_addr_WB  <= w_headAddr;
            rd_data_WB  <= w_headData;
            grant_WB    <= w_pop;
            exc_WB      <= w_headExc;
            r_lastGrant <= w_sel;
        end
    end

    assign busy = ~&w_empty;

`ifdef WB_ARB_PERF_EN
    logic w_stall;
    assign w_stall = |(ch_valid & ~ch_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wb_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (rd_wena_WB) begin
                perf_wb_cnt <= perf_wb_cnt + 32'd1;
            end
            if (w_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    // Counters compiled out; the datapath above is unaffected.
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter checked against a queue-based reference model.
// Counter checks are enabled when WB_ARB_PERF_EN is defined.
module tb_wb_arbiter;

    localparam int N     = 2;
    localparam int DEPTH = 2;
    localparam int AW    = 6;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          e;
    } entry_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush_in;
    logic [N-1:0]      ch_valid;
    logic [N-1:0]      ch_ready;
    logic [N*AW-1:0]   ch_rd_addr;
    logic [N*DW-1:0]   ch_rd_data;
    logic [N-1:0]      ch_exc;
    logic              rd_wena_WB;
    logic [AW-1:0]     rd_addr_WB;
    logic [DW-1:0]     rd_data_WB;
    logic [N-1:0]      grant_WB;
    logic              exc_WB;
    logic              busy;
`ifdef WB_ARB_PERF_EN
    logic [31:0]       perf_wb_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    wb_arbiter #(.N_CH(N), .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .reset(reset),
        .flush_in(flush_in),
        .ch_valid(ch_valid),
        .ch_ready(ch_ready),
        .ch_rd_addr(ch_rd_addr),
        .ch_rd_data(ch_rd_data),
        .ch_exc(ch_exc),
        .rd_wena_WB(rd_wena_WB),
        .rd_addr_WB(rd_addr_WB),
        .rd_data_WB(rd_data_WB),
        .grant_WB(grant_WB),
        .exc_WB(exc_WB),
        .busy(busy)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_wb_cnt(perf_wb_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    entry_t        q [N][$];
    int            lastGrant;
    logic          mWena;
    logic [N-1:0]  mGrant;
    logic          mExc;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData;
    logic [31:0]   mPerfWb;
    logic [31:0]   mPerfStall;
    int            errors = 0;
    int            checks = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) q[i].delete();
        mWena      = 1'b0;
        mGrant     = '0;
        mExc       = 1'b0;
        mAddr      = '0;
        mData      = '0;
        lastGrant  = N - 1;
        mPerfWb    = '0;
        mPerfStall = '0;
    endtask

    // One rising edge of the reference: pop decided on the pre-edge queues, then accepted pushes appended.
    task automatic modelEdge(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                             input logic [N-1:0] e, input logic f, input logic [N-1:0] rdy);
        bit     found;
        int     c;
        entry_t ent;
        entry_t nw;
        if (mWena) mPerfWb = mPerfWb + 32'd1;
        if (|(v & ~rdy)) mPerfStall = mPerfStall + 32'd1;
        if (f) begin
            for (int i = 0; i < N; i++) q[i].delete();
            mWena  = 1'b0;
            mGrant = '0;
            mExc   = 1'b0;
            return;
        end
        found = 0;
        for (int k = 1; k <= N; k++) begin
            c = (lastGrant + k) % N;
            if (!found && q[c].size() > 0) begin
                found     = 1;
                ent       = q[c].pop_front();
                mGrant    = '0;
                mGrant[c] = 1'b1;
                mExc      = ent.e;
                mWena     = !ent.e && (ent.a != '0);
                mAddr     = ent.a;
                mData     = ent.d;
                lastGrant = c;
            end
        end
        if (!found) begin
            mWena  = 1'b0;
            mGrant = '0;
            mExc   = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && rdy[i]) begin
                nw.a = a[i*AW +: AW];
                nw.d = d[i*DW +: DW];
                nw.e = e[i];
                q[i].push_back(nw);
            end
        end
    endtask

    // Called at a falling edge; drives one cycle of inputs, checks ready, steps the model, checks outputs.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                                 input logic [N-1:0] e, input logic f, input logic r);
        logic [N-1:0] expRdy;
        logic         expBusy;
        ch_valid   = v;
        ch_rd_addr = a;
        ch_rd_data = d;
        ch_exc     = e;
        flush_in   = f;
        reset      = r;
        #1;
        for (int i = 0; i < N; i++) expRdy[i] = (q[i].size() < DEPTH) && !f;
        checkOutput("ch_ready", 64'(ch_ready), 64'(expRdy));
        @(posedge clk);
        if (r) modelReset();
        else modelEdge(v, a, d, e, f, expRdy);
        @(negedge clk);
        expBusy = 1'b0;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) expBusy = 1'b1;
        checkOutput("rd_wena_WB", 64'(rd_wena_WB), 64'(mWena));
        checkOutput("grant_WB",   64'(grant_WB),   64'(mGrant));
        checkOutput("exc_WB",     64'(exc_WB),     64'(mExc));
        checkOutput("rd_addr_WB", 64'(rd_addr_WB), 64'(mAddr));
        checkOutput("rd_data_WB", 64'(rd_data_WB), 64'(mData));
        checkOutput("busy",       64'(busy),       64'(expBusy));
`ifdef WB_ARB_PERF_EN
        checkOutput("perf_wb_cnt",    64'(perf_wb_cnt),    64'(mPerfWb));
        checkOutput("perf_stall_cnt", 64'(perf_stall_cnt), 64'(mPerfStall));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        flush_in   = 1'b0;
        ch_valid   = '0;
        ch_rd_addr = '0;
        ch_rd_data = '0;
        ch_exc     = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("[TB] reset state");
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b1);
        checkOutput("reset_ready", 64'(ch_ready), 64'(2'b11));

        $display("[TB] single push");
        applyStimulus(2'b01, {6'd0, 6'd5}, {32'd0, 32'hDEADBEEF}, '0, 1'b0, 1'b0);
        idle(1);
        checkOutput("single_wena",  64'(rd_wena_WB), 64'd1);
        checkOutput("single_addr",  64'(rd_addr_WB), 64'd5);
        checkOutput("single_data",  64'(rd_data_WB), 64'hDEADBEEF);
        checkOutput("single_grant", 64'(grant_WB),   64'(2'b01));
        idle(1);

        $display("[TB] round robin");
        for (int i = 0; i < 6; i++)
            applyStimulus(2'b11, {6'(20 + i), 6'(10 + i)}, {32'(200 + i), 32'(100 + i)}, '0, 1'b0, 1'b0);
        idle(6);

        $display("[TB] suppression");
        applyStimulus(2'b01, {6'd0, 6'd0}, {32'd0, 32'd7}, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b01, {6'd0, 6'd3}, {32'd0, 32'd9}, 2'b01, 1'b0, 1'b0);
        checkOutput("supp0_wena",  64'(rd_wena_WB), 64'd0);
        checkOutput("supp0_exc",   64'(exc_WB),     64'd0);
        checkOutput("supp0_grant", 64'(grant_WB),   64'(2'b01));
        idle(1);
        checkOutput("supp1_wena",  64'(rd_wena_WB), 64'd0);
        checkOutput("supp1_exc",   64'(exc_WB),     64'd1);
        checkOutput("supp1_grant", 64'(grant_WB),   64'(2'b01));
        idle(2);

        $display("[TB] full boundary");
        for (int i = 0; i < 5; i++)
            applyStimulus(2'b11, {6'(40 + i), 6'(30 + i)}, {32'(400 + i), 32'(300 + i)}, '0, 1'b0, 1'b0);
        idle(8);

        $display("[TB] flush");
        applyStimulus(2'b11, {6'd12, 6'd11}, {32'd12, 32'd11}, '0, 1'b0, 1'b0);
        applyStimulus(2'b11, {6'd14, 6'd13}, {32'd14, 32'd13}, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, '0, '0, 1'b1, 1'b0);
        checkOutput("flush_busy", 64'(busy), 64'd0);
        idle(3);

        $display("[TB] reset mid-operation");
        applyStimulus(2'b11, {6'd16, 6'd15}, {32'd16, 32'd15}, '0, 1'b0, 1'b0);
        applyStimulus(2'b11, {6'd18, 6'd17}, {32'd18, 32'd17}, '0, 1'b0, 1'b0);
        applyStimulus(2'b11, '0, '0, '0, 1'b1, 1'b1);
        applyStimulus(2'b11, {6'd22, 6'd21}, {32'd22, 32'd21}, '0, 1'b0, 1'b0);
        idle(1);
        checkOutput("post_reset_grant", 64'(grant_WB), 64'(2'b01));
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] e;
            for (int j = 0; j < N; j++) e[j] = ($urandom % 8) == 0;
            applyStimulus(N'($urandom),
                          {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))},
                          {32'($urandom), 32'($urandom)},
                          e,
                          ($urandom % 25) == 0,
                          ($urandom % 70) == 0);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The module SHALL have parameter N_CH, default 2: number of result channels, 2..8.
REQ-002 The module SHALL have parameter DEPTH, default 2: entries per channel FIFO, power of two, 2..16.
REQ-003 The module SHALL have parameter ADDR_W, default 6: destination address width; bit ADDR_W-1 set selects the FP file.
REQ-004 The module SHALL have parameter DATA_W, default 32: result data width.
REQ-005 The module SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 The module SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 The module SHALL have port flush_in, input, 1: discard all buffered results.
REQ-008 The module SHALL have port ch_valid, input, N_CH: per-channel result valid.
REQ-009 The module SHALL have port ch_ready, output, N_CH: per-channel accept.
REQ-010 The module SHALL have port ch_rd_addr, input, N_CH*ADDR_W: destination addresses, channel i in slice i.
REQ-011 The module SHALL have port ch_rd_data, input, N_CH*DATA_W: result data, channel i in slice i.
REQ-012 The module SHALL have port ch_exc, input, N_CH: result carries an exception; suppress the write.
REQ-013 The module SHALL have output rd_wena_WB (1), rd_addr_WB (ADDR_W) and rd_data_WB (DATA_W): the register-file write port.
REQ-014 The module SHALL have output grant_WB (N_CH, one-hot or zero): channel retired this cycle.
REQ-015 The module SHALL have output exc_WB (1): the retired entry had ch_exc set.
REQ-016 The module SHALL have output busy (1): any FIFO non-empty.

Function
REQ-017 Channel i SHALL push an entry {addr, data, exc} when ch_valid[i] && ch_ready[i] at a rising edge.
REQ-018 ch_ready[i] SHALL be !full[i] && !flush_in, independent of ch_valid.
REQ-019 ch_ready SHALL NOT pass through on a simultaneous pop: a full FIFO refuses the push even in a cycle where it pops.
REQ-020 Each edge, the arbiter SHALL pop exactly one head from the non-empty FIFOs and register it onto the write port.
REQ-021 Arbitration SHALL be round-robin: priority starts at last_grant+1 modulo N_CH; after reset last_grant = N_CH-1, so channel 0 has first priority.
REQ-022 Latency SHALL be: push at edge k, with no competition, gives outputs valid in the cycle after edge k+1.
REQ-023 rd_wena_WB SHALL be 1 for a popped entry unless exc = 1 or addr = 0.
REQ-024 grant_WB and exc_WB SHALL be asserted for the popped entry even when the write is suppressed.
REQ-025 With no entry popped, rd_wena_WB, grant_WB and exc_WB SHALL be 0, and rd_addr_WB/rd_data_WB SHALL hold their previous values.
REQ-026 A FIFO SHALL support a push and a pop at the same edge, with count unchanged.
REQ-027 Pointers SHALL wrap at DEPTH with separate full and empty detection, so that the count range 0..DEPTH is exact.
REQ-028 flush_in at an edge SHALL empty all FIFOs and zero rd_wena_WB/grant_WB/exc_WB; no push or pop SHALL occur at that edge; last_grant SHALL be unchanged.
REQ-029 The write port SHALL retire entries of the same channel in push order; no order between channels is guaranteed.

Reset
REQ-030 reset SHALL have priority over flush_in.
REQ-031 At reset all FIFOs SHALL be empty, ch_ready SHALL be all ones, and rd_wena_WB, grant_WB, exc_WB and busy SHALL be 0.
REQ-032 At reset rd_addr_WB and rd_data_WB SHALL be 0 and last_grant SHALL be N_CH-1.
REQ-033 reset asserted mid-operation SHALL discard all buffered entries with no write issued.

Configuration
REQ-034 The macro WB_ARB_PERF_EN SHALL control the performance counters.
REQ-035 With WB_ARB_PERF_EN defined, the module SHALL add 32-bit outputs perf_wb_cnt (counts suppressed-free writes, rd_wena_WB) and perf_stall_cnt (counts cycles with any ch_valid[i] && !ch_ready[i]).
REQ-036 Both counters SHALL wrap modulo 2^32 and SHALL be cleared by reset, not by flush_in.
REQ-037 Without WB_ARB_PERF_EN, the ports and logic SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-038 Single push: ch0 pushes addr=5, data=0xDEADBEEF at edge k -> the cycle after edge k+1 shows rd_wena_WB=1, addr 5, data 0xDEADBEEF, grant_WB=01.
REQ-039 Round-robin: N_CH=2, both channels push every cycle for 6 cycles -> grants alternate 01,10,01,...; ch_ready drops only when a FIFO reaches DEPTH.
REQ-040 Suppression: push addr=0 data=7, then addr=3 with ch_exc=1 -> both retire with grant set, rd_wena_WB=0, and exc_WB=0 then 1.
REQ-041 Full boundary: DEPTH=2, ch1 pushes 3 while ch0 holds priority -> ch_ready[1]=0 after 2 entries; the third entry is accepted only after a ch1 pop; order is preserved.
REQ-042 Flush/reset: 3 entries buffered, flush_in pulsed -> no writes follow, busy=0 next cycle; repeat with reset -> outputs 0 and last_grant returns to give ch0 first priority.
REQ-043 With WB_ARB_PERF_EN: 4 writes and 2 stall cycles -> perf_wb_cnt=4, perf_stall_cnt=2; after flush the counters are unchanged.
